// File: rtl/phy_rx_pkg.sv
// Shared receive-path definitions: comma character, alignment FSM states and
// a saturating counter helper.
package phy_rx_pkg;

    localparam logic [7:0] COMMA_DEF = 8'hBC;

    typedef enum logic [1:0] {
        HUNT     = 2'd0,
        SETTLE_W = 2'd1,
        CHECK    = 2'd2,
        SYNC     = 2'd3
    } rx_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/rx_sync_ctrl.sv
// Lane alignment controller: hunts for commas, requests bit-slips until they
// land on the byte boundary, then forwards data bytes with commas stripped.
module rx_sync_ctrl
    import phy_rx_pkg::*;
#(
    parameter logic [7:0] COMMA     = COMMA_DEF,
    parameter int         COMMA_REQ = 4,
    parameter int         HUNT_LEN  = 8,
    parameter int         SETTLE    = 2,
    parameter int         MAX_GAP   = 32
) (
    input  logic       clk_f,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       byte_en,
    input  logic       force_resync,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       sync,
    output logic       slip,
    output logic [1:0] state_dbg,
    output logic [7:0] loss_cnt
);

    localparam int HW = $clog2(HUNT_LEN) + 1;
    localparam int CW = $clog2(COMMA_REQ) + 1;
    localparam int SW = $clog2(SETTLE) + 1;
    localparam int GW = $clog2(MAX_GAP) + 1;

    // Valid/ready: there is no backpressure; valid_out qualifies data_out for
    // exactly one cycle and the link layer must accept it on that cycle.

    rx_state_t     state, state_n;
    logic [HW-1:0] hunt_cnt, hunt_n;
    logic [CW-1:0] comma_cnt, comma_n;
    logic [SW-1:0] settle_cnt, settle_n;
    logic [GW-1:0] gap_cnt, gap_n;
    logic [7:0]    data_n, loss_n;
    logic          valid_n, slip_n;
    logic          is_comma;

    assign is_comma  = (byte_in == COMMA);
    assign sync      = (state == SYNC);
    assign state_dbg = state;

    always_comb begin
        state_n  = state;
        hunt_n   = hunt_cnt;
        comma_n  = comma_cnt;
        settle_n = settle_cnt;
        gap_n    = gap_cnt;
        data_n   = data_out;
        loss_n   = loss_cnt;
        valid_n  = 1'b0;
        slip_n   = 1'b0;

        if (force_resync) begin
            state_n  = HUNT;
            hunt_n   = '0;
            comma_n  = '0;
            settle_n = '0;
            gap_n    = '0;
            if (state == SYNC) loss_n = sat_inc8(loss_cnt);
        end else begin
            case (state)
                HUNT: if (byte_en) begin
                    if (is_comma) begin
                        hunt_n = '0;
                        if (COMMA_REQ == 1) begin
                            state_n = SYNC;
                            gap_n   = '0;
                        end else begin
                            state_n = CHECK;
                            comma_n = CW'(1);
                        end
                    end else if (hunt_cnt == HW'(HUNT_LEN - 1)) begin
                        state_n  = SETTLE_W;
                        slip_n   = 1'b1;
                        hunt_n   = '0;
                        settle_n = '0;
                    end else begin
                        hunt_n = hunt_cnt + HW'(1);
                    end
                end
                // The deserializer output is garbage while the boundary moves,
                // so this wait runs on clk_f regardless of byte_en.
                SETTLE_W: begin
                    if (settle_cnt == SW'(SETTLE - 1)) begin
                        state_n  = HUNT;
                        settle_n = '0;
                        hunt_n   = '0;
                    end else begin
                        settle_n = settle_cnt + SW'(1);
                    end
                end
                CHECK: if (byte_en) begin
                    if (is_comma) begin
                        if (comma_cnt == CW'(COMMA_REQ - 1)) begin
                            state_n = SYNC;
                            comma_n = '0;
                            gap_n   = '0;
                        end else begin
                            comma_n = comma_cnt + CW'(1);
                        end
                    end else begin
                        state_n = HUNT;
                        comma_n = '0;
                        hunt_n  = HW'(1);
                    end
                end
                SYNC: if (byte_en) begin
                    if (is_comma) begin
                        gap_n = '0;
                    end else if (gap_cnt < GW'(MAX_GAP)) begin
                        data_n  = byte_in;
                        valid_n = 1'b1;
                        gap_n   = gap_cnt + GW'(1);
                    end else begin
                        state_n = HUNT;
                        gap_n   = '0;
                        hunt_n  = '0;
                        loss_n  = sat_inc8(loss_cnt);
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk_f) begin
        if (!reset) begin
            state      <= HUNT;
            hunt_cnt   <= '0;
            comma_cnt  <= '0;
            settle_cnt <= '0;
            gap_cnt    <= '0;
            data_out   <= '0;
            valid_out  <= 1'b0;
            slip       <= 1'b0;
            loss_cnt   <= '0;
        end else begin
            state      <= state_n;
            hunt_cnt   <= hunt_n;
            comma_cnt  <= comma_n;
            settle_cnt <= settle_n;
            gap_cnt    <= gap_n;
            data_out   <= data_n;
            valid_out  <= valid_n;
            slip       <= slip_n;
            loss_cnt   <= loss_n;
        end
    end

endmodule
